gf_mul_arb: RTL and testbench

Round-robin arbiter and result sequencer that shares one GF(2^8) multiplier (field polynomial x^8+x^4+x^3+x^2+1, 0x11D) between NREQ requesters. Each requester presents operand pairs on a valid/ready handshake. The block grants one requester per cycle and drives the shared multiplier with that requester's operands. It returns the registered product, tagged with the requester index, on a single valid/ready response port. The block sits between Reed-Solomon encoder/syndrome lanes and the shared multiplier resource.

---
 rtl/gf_pkg.sv | 21 ++
 rtl/gf_mul_core.sv | 13 +
 rtl/gf_mul_arb.sv | 158 +++++++++++++++
 tb/tb_gf_mul_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: field polynomial 0x11D, element type, multiply-and-reduce.
package gf_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;

    typedef logic [7:0] gf8_t;

    // Carry-less 8x8 product into 15 bits, then fold bits 14..8 back with the polynomial.
    function automatic gf8_t gf_mul_f(input gf8_t a, input gf8_t b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'(GF_POLY) << (i - 8));
        end
        return p[7:0];
    endfunction

endpackage

// File: rtl/gf_mul_core.sv
// The single shared GF(2^8) multiplier (poly 0x11D); purely combinational.
// Latency 0; no flow control of its own.
module gf_mul_core
    import gf_pkg::*;
(
    input  gf8_t a_i,
    input  gf8_t b_i,
    output gf8_t m_o
);

    assign m_o = gf_mul_f(a_i, b_i);

endmodule

// File: rtl/gf_mul_arb.sv
// Round-robin arbiter sharing one GF(2^8) multiplier across NREQ requesters, tagged response.
// Latency 1 cycle accept->rsp_vld; 2 cycles when GF_ARB_PIPE_EN adds the operand stage s1.
// Backpressure: rsp_rdy low holds rsp_m/rsp_id and withholds req_rdy once no stage can advance.
module gf_mul_arb
    import gf_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output gf8_t                 rsp_m,
    output logic [IDW-1:0]       rsp_id
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate the index back.
    function automatic logic [IDW:0] grant_f(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [IDW:0]      off;
        logic [IDW:0]      sum;
        logic              found;
        dbl   = {vld, vld} >> ptr;
        rot   = dbl[NREQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = (IDW+1)'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        return {found, sum[IDW-1:0]};
    endfunction

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_vld_q, rsp_vld_d;
    gf8_t           rsp_m_q, rsp_m_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic [IDW:0]   gnt;
    logic [IDW-1:0] g;
    logic           gnt_any, slot_free, take, xfer;
    gf8_t           sel_a, sel_b, mul_a, mul_b, mul_m;

    assign gnt       = grant_f(req_vld, ptr_q);
    assign g         = gnt[IDW-1:0];
    assign gnt_any   = gnt[IDW];
    assign sel_a     = req_a[int'(g)*8 +: 8];
    assign sel_b     = req_b[int'(g)*8 +: 8];
    assign slot_free = !rsp_vld_q || rsp_rdy;
    assign xfer      = rst_n && gnt_any && take;

`ifdef GF_ARB_PIPE_EN
    logic           s1_vld_q, s1_vld_d;
    gf8_t           s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;

    assign take  = !s1_vld_q || slot_free;
    assign mul_a = s1_a_q;
    assign mul_b = s1_b_q;
`else
    assign take  = slot_free;
    assign mul_a = sel_a;
    assign mul_b = sel_b;
`endif

    gf_mul_core u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .m_o (mul_m)
    );

    always_comb begin
        req_rdy = '0;
        if (xfer) req_rdy[g] = 1'b1;
    end

    always_comb begin
        ptr_d     = ptr_q;
        rsp_vld_d = rsp_vld_q;
        rsp_m_d   = rsp_m_q;
        rsp_id_d  = rsp_id_q;
        if (xfer) ptr_d = (g == LAST_ID) ? '0 : g + 1'b1;
`ifdef GF_ARB_PIPE_EN
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        if (xfer) begin
            s1_vld_d = 1'b1;
            s1_a_d   = sel_a;
            s1_b_d   = sel_b;
            s1_id_d  = g;
        end else if (slot_free) begin
            s1_vld_d = 1'b0;
        end
        if (slot_free) begin
            rsp_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                rsp_m_d  = mul_m;
                rsp_id_d = s1_id_q;
            end
        end
`else
        if (xfer) begin
            rsp_vld_d = 1'b1;
            rsp_m_d   = mul_m;
            rsp_id_d  = g;
        end else if (rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_m_q   <= '0;
            rsp_id_q  <= '0;
`ifdef GF_ARB_PIPE_EN
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_id_q   <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_m_q   <= rsp_m_d;
            rsp_id_q  <= rsp_id_d;
`ifdef GF_ARB_PIPE_EN
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_id_q   <= s1_id_d;
`endif
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_m   = rsp_m_q;
    assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_gf_mul_arb.sv
// Scoreboard bench for gf_mul_arb: directed corners, round-robin order, stall, reset, random stress.
module tb_gf_mul_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef GF_ARB_PIPE_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ*8-1:0]   req_a, req_b;
    logic [NREQ-1:0]     req_rdy;
    logic                rsp_vld, rsp_rdy;
    logic [7:0]          rsp_m;
    logic [IDW-1:0]      rsp_id;

    gf_mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_a   (req_a),
        .req_b   (req_b),
        .req_rdy (req_rdy),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_m   (rsp_m),
        .rsp_id  (rsp_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int              exp_q [NREQ][$];
    int              id_log[$];
    int              mdl_ptr = 0;
    int              wait_cnt[NREQ];
    logic [NREQ-1:0] acc_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiply by shift-and-add with a per-step xtime reduction (0x11D).
    function automatic int ref_mul(input int a, input int b);
        int r, x, bb;
        r = 0; x = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb & 1) r = r ^ x;
            bb = bb >> 1;
            x  = x << 1;
            if (x & 'h100) x = x ^ 'h11D;
        end
        return r & 'hFF;
    endfunction

    // Monitor: samples on the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                exp_q[i].delete();
                wait_cnt[i] = 0;
            end
            mdl_ptr  = 0;
            acc_last = '0;
        end else begin
            int eg;
            logic [NREQ-1:0] exp_rdy;
            eg = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (eg < 0 && req_vld[(mdl_ptr + k) % NREQ]) eg = (mdl_ptr + k) % NREQ;
            end
            exp_rdy = (eg >= 0) ? NREQ'(1 << eg) : '0;
            check("rdy_onehot", ($countones(req_rdy) <= 1), 1);
`ifdef GF_ARB_PIPE_EN
            if (req_rdy != '0) check("grant", req_rdy, exp_rdy);
`else
            check("grant", req_rdy, (!rsp_vld || rsp_rdy) ? exp_rdy : '0);
`endif
            acc_last = req_vld & req_rdy;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_last[i]) begin
                    exp_q[i].push_back(ref_mul(int'(req_a[i*8 +: 8]), int'(req_b[i*8 +: 8])));
                    mdl_ptr = (i + 1) % NREQ;
                end
                if (acc_last != '0) begin
                    if (acc_last[i] || !req_vld[i]) wait_cnt[i] = 0;
                    else begin
                        wait_cnt[i]++;
                        check("fairness", (wait_cnt[i] < NREQ), 1);
                    end
                end
            end
            if (rsp_vld && rsp_rdy) begin
                id_log.push_back(int'(rsp_id));
                check("rsp_pending", (exp_q[rsp_id].size() > 0), 1);
                if (exp_q[rsp_id].size() > 0) check("rsp_m", rsp_m, exp_q[rsp_id].pop_front());
            end
        end
    end

    task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input string nm);
        int cnt;
        cnt = 0;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_vld = NREQ'(1 << id);
        @(negedge clk);
        while (!req_rdy[id] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_accept"}, req_rdy[id], 1);
        @(posedge clk);
        #1 req_vld = '0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check({nm, "_vld"}, rsp_vld, 1);
        check({nm, "_m"}, rsp_m, exp);
        check({nm, "_id"}, rsp_id, id);
    endtask

    initial begin
        logic [7:0]     hold_m;
        logic [IDW-1:0] hold_id;
        rst_n   = 1'b0;
        req_vld = '1;
        req_a   = '0;
        req_b   = '0;
        rsp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_rsp_vld", rsp_vld, 0);
        check("reset_rsp_m", rsp_m, 8'h00);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_req_rdy", req_rdy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = '0;

        single(0, 8'h02, 8'h80, 8'h1D, "mul_02_80");
        single(1, 8'h80, 8'h80, 8'h13, "mul_80_80");
        single(2, 8'h02, 8'h8E, 8'h01, "mul_02_8e");
        single(3, 8'h00, 8'hFF, 8'h00, "mul_00_ff");
        @(posedge clk);
        #1;

        // All requesters valid: strict rotation starting at 0, one result per cycle.
        id_log.delete();
        req_vld = '1;
        for (int c = 0; c < 16; c++) begin
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("rr_count", id_log.size(), 16);
        for (int k = 0; k < 16 && k < id_log.size(); k++) check("rr_order", id_log[k], k % NREQ);

        // Stall with a result pending.
        req_vld = '1;
        repeat (3) begin
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        rsp_rdy = 1'b0;
        @(negedge clk);
        check("stall_vld", rsp_vld, 1);
        hold_m  = rsp_m;
        hold_id = rsp_id;
        if (LAT == 1) check("stall_rdy", req_rdy, 0);
        repeat (4) begin
            @(negedge clk);
            check("stall_m", rsp_m, hold_m);
            check("stall_id", rsp_id, hold_id);
            check("stall_rdy", req_rdy, 0);
        end
        @(posedge clk);
        #1 rsp_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1 req_vld = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset with a product held and ptr at 2.
        rsp_rdy = 1'b0;
        single(1, 8'h53, 8'hCA, 8'h8F, "pre_reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drop_vld", rsp_vld, 0);
        check("rst_req_rdy", req_rdy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = 4'b1010;
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("rst_first_grant", req_rdy, 4'b0010);
        @(posedge clk);
        #1 req_vld = 4'b1000;
        @(negedge clk);
        check("rst_second_grant", req_rdy, 4'b1000);
        @(posedge clk);
        #1 req_vld = '0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Random stress: valids held until accepted, random response backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_last[i] || !req_vld[i]) begin
                    req_vld[i]       = ($urandom_range(0, 99) < 60);
                    req_a[i*8 +: 8]  = 8'($urandom);
                    req_b[i*8 +: 8]  = 8'($urandom);
                end
            end
            rsp_rdy = ($urandom_range(0, 99) < 70);
            @(posedge clk);
            #1;
        end
        req_vld = '0;
        rsp_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) check("drain_empty", exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
